// File: rtl/sseg_scan_display.sv
// Multiplexed common-anode seven-segment driver: a sequential shift-add-3 (or hex
// pass-through) converter feeding a scanned display with leading-zero blanking.
module sseg_scan_display #(
    parameter int VALUE_WIDTH = 16,
    parameter int DIGITS      = 5,
    parameter int REFRESH_DIV = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [VALUE_WIDTH-1:0] value,
    input  logic                   hex_mode,
    input  logic                   blank_zeros,
    output logic [7:0]             sseg_indicator,
    output logic [DIGITS-1:0]      digits,
    output logic                   busy,
    output logic                   overflow
);

    localparam int ACC_W = DIGITS * 4;
    localparam int CNT_W = $clog2(VALUE_WIDTH + 1);
    localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        LOAD,
        SHIFT,
        COMMIT
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [VALUE_WIDTH-1:0] shadow;
    logic                   shadow_hex;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       acc_adj;
    logic                   conv_ovf;
    logic [CNT_W-1:0]       cnt;
    logic [ACC_W-1:0]       disp;

    logic [DIV_W-1:0]       div;
    logic [PTR_W-1:0]       ptr;
    logic                   tick;
    logic [3:0]             nibble;
    logic                   upper_zero;
    logic [7:0]             pattern;

    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 8'hC0;
            4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;
            4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;
            4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;
            4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;
            4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;
            4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;
            4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;
            4'hF: glyph = 8'h8E;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        acc_adj = acc;
        if (!shadow_hex) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (acc[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    state_next = SHIFT;
            SHIFT:   if (cnt == CNT_W'(VALUE_WIDTH - 1)) state_next = COMMIT;
            COMMIT:  state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) state <= LOAD;
        else        state <= state_next;
    end

    // busy is registered from next-state, so it reads low while reset is held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow     <= '0;
            shadow_hex <= 1'b0;
            acc        <= '0;
            conv_ovf   <= 1'b0;
            cnt        <= '0;
            disp       <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            busy <= (state_next != COMMIT);
            case (state)
                LOAD: begin
                    shadow     <= value;
                    shadow_hex <= hex_mode;
                    acc        <= '0;
                    cnt        <= '0;
                    conv_ovf   <= 1'b0;
                end
                SHIFT: begin
                    acc    <= {acc_adj[ACC_W-2:0], shadow[VALUE_WIDTH-1]};
                    shadow <= shadow << 1;
                    cnt    <= cnt + 1'b1;
                    if (acc_adj[ACC_W-1]) conv_ovf <= 1'b1;
                end
                COMMIT: begin
                    disp     <= acc;
                    overflow <= conv_ovf;
                end
                default: ;
            endcase
        end
    end

    assign tick = (div == DIV_W'(REFRESH_DIV - 1));

    always_comb begin
        nibble     = 4'd0;
        upper_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (PTR_W'(j) == ptr) nibble = disp[j*4 +: 4];
            if (PTR_W'(j) >= ptr && disp[j*4 +: 4] != 4'd0) upper_zero = 1'b0;
        end
    end

    always_comb begin
        pattern = glyph(nibble);
        if (overflow)                                   pattern = 8'hBF;
        else if (blank_zeros && ptr != '0 && upper_zero) pattern = 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div            <= '0;
            ptr            <= '0;
            digits         <= '0;
            sseg_indicator <= 8'hFF;
        end else if (tick) begin
            div            <= '0;
            digits         <= DIGITS'(1) << ptr;
            sseg_indicator <= pattern;
            ptr            <= (ptr == PTR_W'(DIGITS - 1)) ? '0 : ptr + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule
